// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the shift_reg_bank storage/serialiser element.
// Mode encodings, FSM state enum and a helper that classifies burst-capable modes.
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROTL = 3'b100;
  localparam mode_t MODE_ROTR = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;
  localparam mode_t MODE_INV  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Only the four shift/rotate modes can be repeated as a counted burst.
  function automatic logic is_burst_mode(input mode_t m);
    return (m >= MODE_SHL) && (m <= MODE_ROTR);
  endfunction

endpackage

// File: rtl/shift_reg_next.sv
// Combinational next-value function of the register: one result per mode.
// Shared by single-step operations and burst steps.
module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      MODE_INV:  q_next = ~q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_bank.sv
// WIDTH-bit register with true/complement outputs, eight modes and a counted
// burst engine that repeats a shift/rotate N times and pulses done at the end.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | single-step operations on en; burst_start may launch a burst
//   ST_BURST | latched shift/rotate applied on each en edge until count hits 0
module shift_reg_bank
  import shift_reg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mode_t            bmode, bmode_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] q_calc;
  logic [CNT_W-1:0] len_clamped;

  assign op_mode     = (state == ST_BURST) ? bmode : mode;
  assign len_clamped = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;

  shift_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode   (op_mode),
    .q      (q),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (q_calc)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bmode_nxt = bmode;
    q_nxt     = q;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A valid burst request wins over the single-step operation this edge.
        if (burst_start && is_burst_mode(mode)) begin
          if (len_clamped != '0) begin
            bmode_nxt = mode;
            cnt_nxt   = len_clamped;
            state_nxt = ST_BURST;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (en) begin
          q_nxt = q_calc;
        end
      end
      ST_BURST: begin
        if (en) begin
          q_nxt   = q_calc;
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bmode <= MODE_HOLD;
      q     <= RESET_VAL;
      qb    <= ~RESET_VAL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bmode <= bmode_nxt;
      q     <= q_nxt;
      qb    <= ~q_nxt;
      busy  <= (state_nxt == ST_BURST);
      done  <= done_nxt;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule
